alu_share_arbiter: RTL and testbench

Shares one instance of the team's combinational alu between two requesters: port 0 is the integer execute path and port 1 is the address/branch helper. The block arbitrates with valid/ready handshakes and registers the ALU result and flags into a single output stage. The response is tagged with the winning requester's ID and supports backpressure. Arbitration is round-robin by default.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 49 ++++
 rtl/rr_arb2.sv | 56 +++++
 rtl/alu_share_arbiter.sv | 102 ++++++++++
 tb/tb_alu_share_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code encoding and widths used by the alu
// and by the shared-ALU arbiter.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int REQ_ID_W   = 1;

  localparam logic [ALU_CTRL_W-1:0] ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] SLT  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] SLL  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] SRL  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] SRA  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] SLTU = 4'b1101;

endpackage

// File: rtl/alu.sv
// Combinational ALU. The zero flag follows the result; less_than and
// unsigned_less_than always compare the operands, independent of the op.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]      alu_out,
  output logic                  zero,
  output logic                  less_than,
  output logic                  unsigned_less_than
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt_s;
  logic            lt_s;
  logic            ltu_s;

  assign shamt_s = b[SH_W-1:0];
  assign lt_s    = $signed(a) < $signed(b);
  assign ltu_s   = a < b;

  // Operation select; unsupported codes yield zero
  always_comb begin
    alu_out = {WIDTH{1'b0}};
    case (alu_ctrl)
      ADD:     alu_out = a + b;
      SUB:     alu_out = a - b;
      AND:     alu_out = a & b;
      OR:      alu_out = a | b;
      XOR:     alu_out = a ^ b;
      SLT:     alu_out = {{(WIDTH-1){1'b0}}, lt_s};
      SLL:     alu_out = a << shamt_s;
      SRL:     alu_out = a >> shamt_s;
      SRA:     alu_out = $signed(a) >>> shamt_s;
      SLTU:    alu_out = {{(WIDTH-1){1'b0}}, ltu_s};
      default: alu_out = {WIDTH{1'b0}};
    endcase
  end

  assign zero               = (alu_out == {WIDTH{1'b0}});
  assign less_than          = lt_s;
  assign unsigned_less_than = ltu_s;

endmodule

// File: rtl/rr_arb2.sv
// Two-way grant logic gated by output-stage availability. Round-robin by
// default; ALU_ARB_FIXED_PRIO_EN makes requester 0 the fixed winner.
module rr_arb2 (
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic valid0,
  input  logic valid1,
  input  logic out_free,
  output logic grant0,
  output logic grant1
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  assign grant0 = out_free & valid0;
  assign grant1 = out_free & valid1 & ~valid0;

`else

  logic last_grant_r;

  // Ties go to the requester that did not win last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (out_free) begin
      if (valid0 && valid1) begin
        if (last_grant_r) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Remember the most recent winner; reset value lets requester 0 win first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (grant0 || grant1) begin
      last_grant_r <= grant1;
    end
  end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// One alu shared by two valid/ready requesters with a single registered
// response stage. Build option: ALU_ARB_FIXED_PRIO_EN (fixed priority to port 0).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_zero,
  output logic              resp_lt,
  output logic              resp_ltu
);

  logic              out_free_s;
  logic              grant0_s;
  logic              grant1_s;
  logic [WIDTH-1:0]  alu_a_s;
  logic [WIDTH-1:0]  alu_b_s;
  logic [CTRL_W-1:0] alu_ctrl_s;
  logic [WIDTH-1:0]  alu_out_s;
  logic              alu_zero_s;
  logic              alu_lt_s;
  logic              alu_ltu_s;

  // Readys depend combinationally on resp_ready; there is no skid buffer
  assign out_free_s = ~resp_valid | resp_ready;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  rr_arb2 u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .out_free (out_free_s),
    .grant0   (grant0_s),
    .grant1   (grant1_s)
  );

  // Steer the winner's operands into the shared alu
  always_comb begin
    if (grant1_s) begin
      alu_a_s    = req1_a;
      alu_b_s    = req1_b;
      alu_ctrl_s = req1_ctrl;
    end else begin
      alu_a_s    = req0_a;
      alu_b_s    = req0_b;
      alu_ctrl_s = req0_ctrl;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a                  (alu_a_s),
    .b                  (alu_b_s),
    .alu_ctrl           (alu_ctrl_s),
    .alu_out            (alu_out_s),
    .zero               (alu_zero_s),
    .less_than          (alu_lt_s),
    .unsigned_less_than (alu_ltu_s)
  );

  // Response stage: load on grant, clear on drain, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= {WIDTH{1'b0}};
      resp_zero  <= 1'b0;
      resp_lt    <= 1'b0;
      resp_ltu   <= 1'b0;
    end else if (grant0_s || grant1_s) begin
      resp_valid <= 1'b1;
      resp_id    <= grant1_s;
      resp_data  <= alu_out_s;
      resp_zero  <= alu_zero_s;
      resp_lt    <= alu_lt_s;
      resp_ltu   <= alu_ltu_s;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a transaction-level model checked
// every negedge, plus directed vectors with hand-computed literal results.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_lt, resp_ltu;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_lt(resp_lt),
    .resp_ltu(resp_ltu)
  );

  always #5 clk = ~clk;

  // Reference model: what the response register must hold
  logic        m_valid = 1'b0;
  logic        m_id = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        m_zero = 1'b0, m_lt = 1'b0, m_ltu = 1'b0;
  logic        m_last = 1'b1;
  logic [1:0]  exp_grant;

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLL:     return a << b[4:0];
      SRL:     return a >> b[4:0];
      SRA:     return 32'($signed(a) >>> b[4:0]);
      SLTU:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Bit 0 = grant to requester 0, bit 1 = grant to requester 1
  function automatic logic [1:0] ref_grant(input logic v0, input logic v1, input logic rr,
                                           input logic held, input logic last);
    if (held && !rr) return 2'b00;
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return (last == 1'b1) ? 2'b01 : 2'b10;
`endif
    end
    return {v1, v0};
  endfunction

  always_comb exp_grant = ref_grant(req0_valid, req1_valid, resp_ready, m_valid, m_last);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_id <= 1'b0; m_data <= 32'd0;
      m_zero <= 1'b0; m_lt <= 1'b0; m_ltu <= 1'b0; m_last <= 1'b1;
    end else if (exp_grant == 2'b01) begin
      m_valid <= 1'b1; m_id <= 1'b0; m_last <= 1'b0;
      m_data <= ref_alu(req0_ctrl, req0_a, req0_b);
      m_zero <= (ref_alu(req0_ctrl, req0_a, req0_b) == 32'd0);
      m_lt <= ($signed(req0_a) < $signed(req0_b)); m_ltu <= (req0_a < req0_b);
    end else if (exp_grant == 2'b10) begin
      m_valid <= 1'b1; m_id <= 1'b1; m_last <= 1'b1;
      m_data <= ref_alu(req1_ctrl, req1_a, req1_b);
      m_zero <= (ref_alu(req1_ctrl, req1_a, req1_b) == 32'd0);
      m_lt <= ($signed(req1_a) < $signed(req1_b)); m_ltu <= (req1_a < req1_b);
    end else if (resp_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, exp_grant[0]});
    chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, exp_grant[1]});
    chk("m_resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
    chk("m_resp_id",    {31'd0, resp_id},    {31'd0, m_id});
    chk("m_resp_data",  resp_data,           m_data);
    chk("m_resp_flags", {29'd0, resp_zero, resp_lt, resp_ltu}, {29'd0, m_zero, m_lt, m_ltu});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_ctrl = 4'd0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_ctrl = 4'd0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", resp_data, 32'd0);

    // 1: single request, 1-cycle latency
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = ADD; resp_ready = 1'b1;
    #1 chk("t1_ready", {31'd0, req0_ready}, 32'd1);
    cyc(); req0_valid = 1'b0;
    chk("t1_valid", {31'd0, resp_valid}, 32'd1);
    chk("t1_id", {31'd0, resp_id}, 32'd0);
    chk("t1_data", resp_data, 32'd12);
    chk("t1_zero", {31'd0, resp_zero}, 32'd0);
    cyc();
    chk("t1_drain", {31'd0, resp_valid}, 32'd0);

    // 2: both valid, alternating grants after a fresh reset
    reset = 1'b1; #1 reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_ctrl = SUB;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'hFFFF_FFFF; req1_ctrl = SLTU;
    #1 chk("t2_g0", {30'd0, req1_ready, req0_ready}, 32'd1);
    cyc();
    chk("t2_r0", {resp_data[29:0], resp_id, resp_zero}, 32'd1);
    chk("t2_g1", {30'd0, req1_ready, req0_ready}, 32'd2);
    cyc();
    chk("t2_r1", {28'd0, resp_id, resp_data[0], resp_ltu, resp_lt}, 32'he);
    chk("t2_g2", {30'd0, req1_ready, req0_ready}, 32'd1);
    cyc();
    chk("t2_id2", {31'd0, resp_id}, 32'd0);
    cyc();
    chk("t2_id3", {31'd0, resp_id}, 32'd1);

    // 3: backpressure holds the result and blocks grants
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
      cyc();
      chk("t3_hold", {resp_data[29:0], resp_id, resp_valid}, 32'd7);
    end
    resp_ready = 1'b1;
    #1 chk("t3_next", {30'd0, req1_ready, req0_ready}, 32'd1);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_r", {30'd0, resp_id, resp_zero}, 32'd1);
    cyc();

    // 4: back-to-back on requester 1, then an unsupported code
    req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_ctrl = SRA;
    cyc();
    req1_a = 32'h1234_5678; req1_b = 32'h0F0F_0F0F; req1_ctrl = XOR;
    chk("t4_sra", resp_data, 32'hF800_0000);
    cyc();
    chk("t4_xor", resp_data, 32'h1D3B_5977);
    chk("t4_b2b", {31'd0, resp_valid}, 32'd1);
    req1_ctrl = 4'hF;
    cyc(); req1_valid = 1'b0;
    chk("t4_bad", {resp_data[30:0], resp_zero}, 32'd1);
    cyc();

    // 5: asynchronous reset drops a held result
    req0_valid = 1'b1; req0_ctrl = ADD; resp_ready = 1'b0;
    cyc(); req0_valid = 1'b0;
    chk("t5_held", {31'd0, resp_valid}, 32'd1);
    reset = 1'b1;
    #1 chk("t5_async", {31'd0, resp_valid}, 32'd0);
    #1 reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    #1 chk("t5_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
    cyc();

`ifdef ALU_ARB_FIXED_PRIO_EN
    // 6: fixed priority always favours requester 0
    for (int i = 0; i < 4; i++) begin
      chk("t6_fixed", {30'd0, req1_ready, req0_ready}, 32'd1);
      cyc();
    end
    req0_valid = 1'b0;
    #1 chk("t6_r1", {30'd0, req1_ready, req0_ready}, 32'd2);
    cyc();
`endif

    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
